// File: rtl/codec_dac_serializer.sv
// WM8731 DAC serializer: master-mode audio interface driver.
// Pops one {left, right} pair per frame from a FWFT FIFO and shifts it out MSB first in
// I2S or left-justified framing. It also generates m_clk, b_clk and dac_lr_clk.
module codec_dac_serializer #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BITS_PER_CH = 32,
  parameter int unsigned BCLK_HALF   = 8,
  parameter int unsigned MCLK_HALF   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fmt_lj,
  input  logic [2*DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic              clr_underrun,
  output logic              underrun,
  output logic              sample_tick,
  output logic              m_clk,
  output logic              b_clk,
  output logic              dac_lr_clk,
  output logic              dacdat
);

  localparam int unsigned FrameBits = 2 * BITS_PER_CH;
  localparam int unsigned BitW      = $clog2(FrameBits);
  localparam int unsigned DivW      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int unsigned MclkW     = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam int unsigned IdxW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [BitW-1:0]  BitLast  = BitW'(FrameBits - 1);
  localparam logic [DivW-1:0]  DivLast  = DivW'(BCLK_HALF - 1);
  localparam logic [MclkW-1:0] MclkLast = MclkW'(MCLK_HALF - 1);

  logic [MclkW-1:0]  mclk_cnt_q;
  logic              m_clk_q;
  logic [DivW-1:0]   div_cnt_q;
  logic              b_clk_q;
  logic [BitW-1:0]   bit_cnt_q;
  logic              dac_lr_q;
  logic              dacdat_q;
  logic              fifo_rd_q;
  logic              sample_tick_q;
  logic              underrun_q;
  logic [DATA_W-1:0] left_sr_q;
  logic [DATA_W-1:0] right_sr_q;
  logic              fmt_lj_q;

  logic              div_last;
  logic              fall;
  logic              frame_start;
  logic [BitW-1:0]   bit_nxt;
  logic [DATA_W-1:0] left_nxt;
  logic [DATA_W-1:0] right_nxt;
  logic [DATA_W-1:0] chan;
  logic              fmt_nxt;
  logic              dat_nxt;
  int unsigned       bit_idx;
  int unsigned       slot;

  // Next-bit decode: dacdat is computed from the post-edge bit_cnt and the data that will be
  // latched, so a frame-start edge already outputs the freshly loaded word.
  always_comb begin
    div_last    = (div_cnt_q == DivLast);
    fall        = div_last && b_clk_q;
    bit_nxt     = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + 1'b1;
    frame_start = fall && (bit_nxt == '0);
    left_nxt    = left_sr_q;
    right_nxt   = right_sr_q;
    fmt_nxt     = fmt_lj_q;
    if (frame_start) begin
      left_nxt  = fifo_empty ? '0 : fifo_data[2*DATA_W-1:DATA_W];
      right_nxt = fifo_empty ? '0 : fifo_data[DATA_W-1:0];
      fmt_nxt   = fmt_lj;
    end
    bit_idx = 32'(bit_nxt);
    slot    = bit_idx % BITS_PER_CH;
    chan    = (bit_idx < BITS_PER_CH) ? left_nxt : right_nxt;
    dat_nxt = 1'b0;
    if (fmt_nxt) begin
      if (slot < DATA_W) dat_nxt = chan[IdxW'(DATA_W - 1 - slot)];
    end else if (slot >= 1 && slot <= DATA_W) begin
      // I2S: one b_clk of delay after the LR transition.
      dat_nxt = chan[IdxW'(DATA_W - slot)];
    end
  end

  // Free-running codec master clock, independent of enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      mclk_cnt_q <= '0;
      m_clk_q    <= 1'b0;
    end else if (mclk_cnt_q == MclkLast) begin
      mclk_cnt_q <= '0;
      m_clk_q    <= ~m_clk_q;
    end else begin
      mclk_cnt_q <= mclk_cnt_q + 1'b1;
    end
  end

  // Bit clock, frame counter, serial data and FIFO pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= '0;
      b_clk_q       <= 1'b0;
      bit_cnt_q     <= BitLast;
      dac_lr_q      <= 1'b1;
      dacdat_q      <= 1'b0;
      fifo_rd_q     <= 1'b0;
      sample_tick_q <= 1'b0;
      left_sr_q     <= '0;
      right_sr_q    <= '0;
      fmt_lj_q      <= 1'b0;
    end else if (!enable) begin
      // Idle: any partial frame is dropped; the next enable restarts from a clean frame.
      div_cnt_q     <= '0;
      b_clk_q       <= 1'b0;
      bit_cnt_q     <= BitLast;
      dac_lr_q      <= 1'b1;
      dacdat_q      <= 1'b0;
      fifo_rd_q     <= 1'b0;
      sample_tick_q <= 1'b0;
    end else begin
      fifo_rd_q     <= frame_start && !fifo_empty;
      sample_tick_q <= frame_start;
      if (div_last) begin
        div_cnt_q <= '0;
        b_clk_q   <= ~b_clk_q;
      end else begin
        div_cnt_q <= div_cnt_q + 1'b1;
      end
      if (fall) begin
        bit_cnt_q  <= bit_nxt;
        dac_lr_q   <= (bit_idx >= BITS_PER_CH);
        dacdat_q   <= dat_nxt;
        left_sr_q  <= left_nxt;
        right_sr_q <= right_nxt;
        fmt_lj_q   <= fmt_nxt;
      end
    end
  end

  // Sticky underrun: a starved frame start beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_q <= 1'b0;
    end else if (enable && frame_start && fifo_empty) begin
      underrun_q <= 1'b1;
    end else if (clr_underrun) begin
      underrun_q <= 1'b0;
    end
  end

  assign fifo_rd     = fifo_rd_q;
  assign underrun    = underrun_q;
  assign sample_tick = sample_tick_q;
  assign m_clk       = m_clk_q;
  assign b_clk       = b_clk_q;
  assign dac_lr_clk  = dac_lr_q;
  assign dacdat      = dacdat_q;

endmodule

// File: tb/tb_codec_dac_serializer.sv
// Bench for codec_dac_serializer: FIFO queue model plus a timing-arithmetic reference.
module tb_codec_dac_serializer;

  localparam int DW    = 16;
  localparam int BPC   = 32;
  localparam int BH    = 8;
  localparam int MH    = 2;
  localparam int FRAME = 2 * BH * 2 * BPC;
  localparam logic [6:0] ResetOut = 7'b0100000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          fmt_lj = 1'b0;
  logic [31:0]   fifo_data = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd;
  logic          clr_underrun = 1'b0;
  logic          underrun;
  logic          sample_tick;
  logic          m_clk;
  logic          b_clk;
  logic          dac_lr_clk;
  logic          dacdat;

  codec_dac_serializer #(
    .DATA_W(DW), .BITS_PER_CH(BPC), .BCLK_HALF(BH), .MCLK_HALF(MH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .fmt_lj(fmt_lj), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .clr_underrun(clr_underrun),
    .underrun(underrun), .sample_tick(sample_tick), .m_clk(m_clk), .b_clk(b_clk),
    .dac_lr_clk(dac_lr_clk), .dacdat(dacdat)
  );

  always #5 clk = ~clk;

  // Model state: n = enabled edges since enable/reset, m_n = edges since reset release.
  logic [31:0] q[$];
  int          n = 0;
  int          m_n = 0;
  logic [32:0] cur = '0;
  logic        cur_fmt = 1'b0;
  logic        und = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [6:0]  exp_v;

  function automatic logic [6:0] obs();
    return {b_clk, dac_lr_clk, dacdat, sample_tick, fifo_rd, underrun, m_clk};
  endfunction

  // Expected outputs after n enabled edges: b_clk edges every BH cycles, a bit per b_clk
  // period starting at the first falling edge (n = 2*BH), a frame every FRAME cycles.
  function automatic logic [6:0] model_out();
    logic bc, lr, dat, tk, rd;
    int k, b, s;
    logic [15:0] w;
    bc = ((n / BH) % 2) == 1;
    lr = 1'b1; dat = 1'b0; tk = 1'b0; rd = 1'b0;
    if (n >= 2 * BH) begin
      k  = n / (2 * BH) - 1;
      b  = k % (2 * BPC);
      s  = b % BPC;
      w  = (b < BPC) ? cur[31:16] : cur[15:0];
      lr = (b >= BPC);
      if (cur_fmt) dat = (s < DW) ? w[DW-1-s] : 1'b0;
      else         dat = (s >= 1 && s <= DW) ? w[DW-s] : 1'b0;
      tk = (n % FRAME) == 2 * BH;
      rd = tk && cur[32];
    end
    return {bc, lr, dat, tk, rd, und, ((m_n / MH) % 2) == 1};
  endfunction

  task automatic refresh();
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() > 0) ? q[0] : '0;
  endtask

  // Advance one clock, update the model, sample outputs 1 time unit after the edge.
  task automatic tick();
    logic run, clr_s, rst_s, fmt_s;
    logic [32:0] head;
    run   = enable && !reset;
    rst_s = reset;
    clr_s = clr_underrun;
    fmt_s = fmt_lj;
    head  = (q.size() > 0) ? {1'b1, q[0]} : 33'd0;
    @(posedge clk);
    #1;
    m_n = rst_s ? 0 : m_n + 1;
    n   = run ? n + 1 : 0;
    if (rst_s) begin
      und = 1'b0; cur = '0; cur_fmt = 1'b0;
    end else if (run && (n % FRAME) == 2 * BH) begin
      cur = head; cur_fmt = fmt_s;
      if (!head[32]) und = 1'b1;
      else if (clr_s) und = 1'b0;
    end else if (clr_s) begin
      und = 1'b0;
    end
    if (fifo_rd && q.size() > 0) void'(q.pop_front());
    refresh();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs() !== ResetOut) begin
        errors++; $display("FAIL reset_state got=%b want=%b", obs(), ResetOut);
      end
    end
    enable = 1'b0; reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(); exp_v = model_out(); checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL idle_mclk n=%0d got=%b want=%b", m_n, obs(), exp_v);
      end
    end
  endtask

  task automatic test_i2s();
    logic [15:0] lacc, racc;
    int rds, b;
    lacc = '0; racc = '0; rds = 0;
    q.push_back(32'hA5C3_0F0F); refresh();
    fmt_lj = 1'b0; enable = 1'b1;
    for (int i = 0; i < 2 * BH + FRAME - 8; i++) begin
      tick(); exp_v = model_out(); checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL i2s_cycle n=%0d got=%b want=%b", n, obs(), exp_v);
      end
      if (fifo_rd) rds++;
      if (n >= 2 * BH && n % (2 * BH) == 0) begin
        b = (n / (2 * BH) - 1) % (2 * BPC);
        if (b >= 1 && b <= 16) lacc = {lacc[14:0], dacdat};
        if (b >= BPC + 1 && b <= BPC + 16) racc = {racc[14:0], dacdat};
      end
    end
    checks++;
    if (lacc !== 16'hA5C3) begin errors++; $display("FAIL i2s_left got=%h want=a5c3", lacc); end
    checks++;
    if (racc !== 16'h0F0F) begin errors++; $display("FAIL i2s_right got=%h want=0f0f", racc); end
    checks++;
    if (rds != 1) begin errors++; $display("FAIL i2s_pops got=%0d want=1", rds); end
    enable = 1'b0; tick(); q.delete(); refresh();
  endtask

  task automatic test_lj();
    q.push_back(32'hA5C3_0F0F); q.push_back($urandom()); refresh();
    fmt_lj = 1'b1; enable = 1'b1;
    for (int i = 0; i < 2 * BH + 2 * FRAME - 8; i++) begin
      tick(); exp_v = model_out(); checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL lj_cycle n=%0d got=%b want=%b", n, obs(), exp_v);
      end
    end
    enable = 1'b0; fmt_lj = 1'b0; tick(); q.delete(); refresh();
  endtask

  task automatic test_back_to_back();
    int last_rd, rds;
    last_rd = -1; rds = 0;
    for (int i = 0; i < 3; i++) q.push_back($urandom());
    refresh(); enable = 1'b1;
    for (int i = 0; i < 2 * BH + 3 * FRAME - 8; i++) begin
      tick(); exp_v = model_out(); checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL b2b_cycle n=%0d got=%b want=%b", n, obs(), exp_v);
      end
      if (fifo_rd) begin
        rds++;
        if (last_rd >= 0) begin
          checks++;
          if (n - last_rd != FRAME) begin
            errors++; $display("FAIL b2b_spacing got=%0d want=%0d", n - last_rd, FRAME);
          end
        end
        last_rd = n;
      end
    end
    checks++;
    if (rds != 3) begin errors++; $display("FAIL b2b_pops got=%0d want=3", rds); end
    enable = 1'b0; tick(); q.delete(); refresh();
  endtask

  task automatic test_underrun();
    q.delete(); refresh(); enable = 1'b1;
    for (int i = 0; i < 2 * BH + 2 * FRAME + 40; i++) begin
      clr_underrun = (n == 1100) || (n == 2 * BH + 2 * FRAME - 1);
      tick(); exp_v = model_out(); checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL und_cycle n=%0d got=%b want=%b", n, obs(), exp_v);
      end
      if (n == 1101) begin
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL und_clear got=%b want=0", underrun); end
      end
      if (n == 2 * BH + 2 * FRAME) begin
        checks++;
        if (underrun !== 1'b1) begin
          errors++; $display("FAIL und_set_wins got=%b want=1", underrun);
        end
      end
    end
    clr_underrun = 1'b0; enable = 1'b0; tick();
    clr_underrun = 1'b1; tick(); clr_underrun = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL und_idle_clear got=%b want=0", underrun); end
  endtask

  task automatic test_reset_mid();
    int first_tick;
    first_tick = -1;
    q.push_back($urandom()); q.push_back($urandom()); refresh(); enable = 1'b1;
    while (n < 2 * BH * 21) begin
      tick(); exp_v = model_out(); checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL rstmid_pre n=%0d got=%b want=%b", n, obs(), exp_v);
      end
    end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if (obs() !== ResetOut) begin
      errors++; $display("FAIL rstmid_state got=%b want=%b", obs(), ResetOut);
    end
    for (int i = 1; i <= 60; i++) begin
      tick(); exp_v = model_out(); checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL rstmid_post n=%0d got=%b want=%b", n, obs(), exp_v);
      end
      if (sample_tick && first_tick < 0) first_tick = i;
    end
    checks++;
    if (first_tick != 2 * BH) begin
      errors++; $display("FAIL rstmid_first_tick got=%0d want=%0d", first_tick, 2 * BH);
    end
    enable = 1'b0; tick(); q.delete(); refresh();
  endtask

  task automatic test_enable_drop();
    int rds;
    rds = 0;
    q.push_back($urandom()); q.push_back($urandom()); refresh(); enable = 1'b1;
    for (int i = 0; i < 500 + 100 + 2 * BH + FRAME - 8; i++) begin
      enable = !(i >= 500 && i < 600);
      tick(); exp_v = model_out(); checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL endrop_cycle i=%0d got=%b want=%b", i, obs(), exp_v);
      end
      if (fifo_rd) rds++;
    end
    checks++;
    if (rds != 2) begin errors++; $display("FAIL endrop_pops got=%0d want=2", rds); end
    enable = 1'b0; tick(); q.delete(); refresh();
  endtask

  initial begin
    refresh();
    test_reset();
    test_i2s();
    test_lj();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
